esm_issue_queue: RTL and testbench
==================================

ESM_ISSUE_QUEUE -- requirements
Module: esm_issue_queue

Interface
REQ-001 Parameter INSTR_W, 32, instruction width; SHALL be >= 25.
REQ-002 Parameter REGNUM, 32, architectural register count; SHALL be a power of 2, <= 32.
REQ-003 Parameter BS, 16, buffer slots; SHALL be a power of 2, >= 2. IW = log2(BS).
REQ-004 Parameter LAT, 2, execute latency in cycles; SHALL be in range 1..8.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  instruction offered.
REQ-008 in_instr  in  INSTR_W  instruction; rd=[11:7], rs1=[19:15], rs2=[24:20], each truncated to log2(REGNUM) bits.
REQ-009 in_alusrc  in  1  1 = immediate operand, rs2 unused.
REQ-010 in_regwrite  in  1  1 = instruction writes rd.
REQ-011 in_ready  out  1  buffer can accept this cycle.
REQ-012 start  in  1  issue enable.
REQ-013 flush  in  1  discard all buffered entries.
REQ-014 issue_valid  out  1  one-cycle issue pulse.
REQ-015 issue_index  out  IW  slot of the issued entry.
REQ-016 issue_instr  out  INSTR_W  instruction of the issued entry.
REQ-017 count  out  IW+1  number of valid entries.

Function
REQ-018 Accept = in_valid & in_ready; in_ready = !rst & (count < BS), with no bypass from a same-cycle issue.
REQ-019 An accepted instruction SHALL be written to the lowest-index free slot and SHALL be valid from the next cycle.
REQ-020 Age SHALL be tracked by a BSxBS age matrix; a new entry is younger than all existing entries.
REQ-021 Register 0, a rd with regwrite=0, and rs2 with alusrc=1 SHALL never create a hazard.
REQ-022 Entry j is blocked by any valid older entry i on RAW (i.rd = j.rs1/rs2), WAW (i.rd = j.rd), or WAR (j.rd = i.rs1/rs2).
REQ-023 Entry j is blocked while the scoreboard counter of any of its live rs1/rs2/rd registers is nonzero.
REQ-024 Ready = valid & !blocked; selection SHALL pick the oldest ready entry and is combinational on state in cycle t.
REQ-025 If start=1 and a ready entry exists in cycle t, then at t+1: issue_valid=1, issue_index=slot, issue_instr=entry instruction, slot freed, and sb[rd]=LAT if rd is live.
REQ-026 Otherwise, issue_valid SHALL be 0 at t+1, and issue_index/issue_instr SHALL hold their last values.
REQ-027 At most one issue per cycle.
REQ-028 Each nonzero sb counter SHALL decrement by 1 per cycle; a register is pending while its counter is nonzero.
REQ-029 A dependent SHALL issue no earlier than LAT+1 cycles after its producer's issue_valid.
REQ-030 Minimum latency from accept to issue_valid, with no hazards and start=1, SHALL be 2 cycles.
REQ-031 The same-cycle issue and accept SHALL both take effect; a freed slot is reusable from the following cycle.
REQ-032 count SHALL equal the previous count, +1 on accept, -1 on issue.
REQ-033 Flush SHALL invalidate all entries, suppress the same-cycle accept and issue (issue_valid=0 next cycle), and leave sb counters running.
REQ-034 Flush with an empty buffer SHALL be a no-op.
REQ-035 start=0 SHALL only stall issue; accepts continue until full.

Reset
REQ-036 While rst=1: all entries invalid, age matrix cleared, all sb counters 0, issue_valid=0, issue_index=0, issue_instr=0, count=0, in_ready=0.
REQ-037 rst SHALL take priority over flush, accept and issue, including when asserted mid-operation with in-flight counters.
REQ-038 In the first cycle after rst deasserts: in_ready=1.

Verification
REQ-039 Reset, start=1, accept A (rd=1, rs1=2) at cycle 0 -> issue_valid at cycle 2, issue_index=0, count returns to 0.
REQ-040 LAT=2: A (rd=1) accepted at cycle 0, B (rs1=1) accepted at cycle 1 -> A issues at cycle 2, B issues at cycle 5.
REQ-041 start=0, accept A (rd=1) then B (rd=3, rs1=4), then start=1 -> A issues before B (oldest first); B then issues on the next cycle.
REQ-042 start=0, fill BS entries -> count=BS and in_ready=0; set start=1 with independent entries -> after the first issue, in_ready=1 and count=BS-1.
REQ-043 Rd=0 producer followed by rs1=0 consumer, and alusrc=1 with matching rs2 -> no stall; issues on consecutive cycles.
REQ-044 Flush with 5 entries and in_valid=1 -> count=0 next cycle, no issue_valid, offered instruction not stored; a pending sb register still blocks a new consumer until its counter expires.

Source files
------------

// File: rtl/esm_issue_queue.sv
// Out-of-order issue buffer: slots ordered by an age matrix, hazards checked against older entries
// plus a per-register countdown scoreboard; the oldest ready entry issues through a registered port.
module esm_issue_queue #(
    parameter int INSTR_W = 32,
    parameter int REGNUM  = 32,
    parameter int BS      = 16,
    parameter int LAT     = 2,
    localparam int IW     = $clog2(BS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               in_alusrc,
    input  logic               in_regwrite,
    output logic               in_ready,
    input  logic               start,
    input  logic               flush,
    output logic               issue_valid,
    output logic [IW-1:0]      issue_index,
    output logic [INSTR_W-1:0] issue_instr,
    output logic [IW:0]        count
);
    localparam int RW  = $clog2(REGNUM);
    localparam int SBW = $clog2(LAT + 1);

    logic [BS-1:0]      valid_q, valid_d;
    logic [BS-1:0]      age_q [BS];
    logic [BS-1:0]      age_d [BS];
    logic [SBW-1:0]     sb_q [REGNUM];
    logic [SBW-1:0]     sb_d [REGNUM];
    logic [INSTR_W-1:0] instr_q [BS];
    logic [RW-1:0]      rd_q [BS];
    logic [RW-1:0]      rs1_q [BS];
    logic [RW-1:0]      rs2_q [BS];
    logic [BS-1:0]      rd_live_q, rs1_live_q, rs2_live_q;
    logic [IW:0]        count_q, count_d;
    logic               issue_valid_q, issue_valid_d;
    logic [IW-1:0]      issue_index_q, issue_index_d;
    logic [INSTR_W-1:0] issue_instr_q, issue_instr_d;

    logic [RW-1:0]      new_rd, new_rs1, new_rs2;
    logic               new_rd_live, new_rs1_live, new_rs2_live;
    logic [BS-1:0]      blocked, ready, has_older_ready;
    logic [IW-1:0]      free_idx, sel_idx;
    logic               sel_found, accept, do_issue;

    // Operand fields; register 0, non-writing rd and immediate rs2 are never live.
    assign new_rd       = in_instr[7 +: RW];
    assign new_rs1      = in_instr[15 +: RW];
    assign new_rs2      = in_instr[20 +: RW];
    assign new_rd_live  = in_regwrite && (new_rd != '0);
    assign new_rs1_live = (new_rs1 != '0);
    assign new_rs2_live = !in_alusrc && (new_rs2 != '0);

    assign in_ready = !rst && (count_q < (IW + 1)'(BS));
    assign accept   = in_valid && in_ready && !flush;
    assign do_issue = start && sel_found && !flush;

    always_comb begin
        free_idx = '0;
        for (int i = BS - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IW'(i);
        end
    end

    // age_q[i][j] set means slot i is older than slot j.
    always_comb begin
        blocked = '0;
        for (int j = 0; j < BS; j++) begin
            if ((rs1_live_q[j] && (sb_q[rs1_q[j]] != '0)) ||
                (rs2_live_q[j] && (sb_q[rs2_q[j]] != '0)) ||
                (rd_live_q[j]  && (sb_q[rd_q[j]]  != '0)))
                blocked[j] = 1'b1;
            for (int i = 0; i < BS; i++) begin
                if (i != j && valid_q[i] && age_q[i][j]) begin
                    if (rd_live_q[i] && rs1_live_q[j] && (rd_q[i] == rs1_q[j])) blocked[j] = 1'b1;
                    if (rd_live_q[i] && rs2_live_q[j] && (rd_q[i] == rs2_q[j])) blocked[j] = 1'b1;
                    if (rd_live_q[i] && rd_live_q[j]  && (rd_q[i] == rd_q[j]))  blocked[j] = 1'b1;
                    if (rd_live_q[j] && rs1_live_q[i] && (rs1_q[i] == rd_q[j])) blocked[j] = 1'b1;
                    if (rd_live_q[j] && rs2_live_q[i] && (rs2_q[i] == rd_q[j])) blocked[j] = 1'b1;
                end
            end
        end
        ready = valid_q & ~blocked;
    end

    always_comb begin
        has_older_ready = '0;
        for (int j = 0; j < BS; j++) begin
            for (int i = 0; i < BS; i++) begin
                if (i != j && ready[i] && age_q[i][j]) has_older_ready[j] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int j = 0; j < BS; j++) begin
            if (ready[j] && !has_older_ready[j]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(j);
            end
        end
    end

    always_comb begin
        valid_d       = valid_q;
        age_d         = age_q;
        count_d       = count_q;
        issue_valid_d = 1'b0;
        issue_index_d = issue_index_q;
        issue_instr_d = issue_instr_q;
        for (int r = 0; r < REGNUM; r++) begin
            sb_d[r] = (sb_q[r] != '0) ? sb_q[r] - SBW'(1) : '0;
        end
        if (flush) begin
            valid_d = '0;
            count_d = '0;
            for (int i = 0; i < BS; i++) age_d[i] = '0;
        end else begin
            if (do_issue) begin
                valid_d[sel_idx] = 1'b0;
                issue_valid_d    = 1'b1;
                issue_index_d    = sel_idx;
                issue_instr_d    = instr_q[sel_idx];
                if (rd_live_q[sel_idx]) sb_d[rd_q[sel_idx]] = SBW'(LAT);
            end
            if (accept) begin
                valid_d[free_idx] = 1'b1;
                age_d[free_idx]   = '0;
                for (int k = 0; k < BS; k++) age_d[k][free_idx] = valid_q[k];
            end
            count_d = count_q + (IW + 1)'(accept) - (IW + 1)'(do_issue);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_index_q <= '0;
            issue_instr_q <= '0;
            for (int i = 0; i < BS; i++) age_q[i] <= '0;
            for (int r = 0; r < REGNUM; r++) sb_q[r] <= '0;
        end else begin
            valid_q       <= valid_d;
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            issue_index_q <= issue_index_d;
            issue_instr_q <= issue_instr_d;
            age_q         <= age_d;
            sb_q          <= sb_d;
        end
    end

    // Payload is only read behind valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            instr_q[free_idx]    <= in_instr;
            rd_q[free_idx]       <= new_rd;
            rs1_q[free_idx]      <= new_rs1;
            rs2_q[free_idx]      <= new_rs2;
            rd_live_q[free_idx]  <= new_rd_live;
            rs1_live_q[free_idx] <= new_rs1_live;
            rs2_live_q[free_idx] <= new_rs2_live;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_index = issue_index_q;
    assign issue_instr = issue_instr_q;
    assign count       = count_q;

endmodule

// File: tb/tb_esm_issue_queue.sv
// Bench for esm_issue_queue: oldest-first queue model checked every cycle, plus directed
// scenarios with hand-computed issue cycles, slots and counts.
module tb_esm_issue_queue;
    localparam int INSTR_W = 32;
    localparam int REGNUM  = 32;
    localparam int BS      = 16;
    localparam int LAT     = 2;
    localparam int IW      = 4;

    logic               clk = 1'b0;
    logic               rst, in_valid, in_alusrc, in_regwrite, start, flush;
    logic [INSTR_W-1:0] in_instr;
    logic               in_ready, issue_valid;
    logic [IW-1:0]      issue_index;
    logic [INSTR_W-1:0] issue_instr;
    logic [IW:0]        count;

    always #5 clk = ~clk;

    esm_issue_queue #(.INSTR_W(INSTR_W), .REGNUM(REGNUM), .BS(BS), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
        .in_alusrc(in_alusrc), .in_regwrite(in_regwrite), .in_ready(in_ready),
        .start(start), .flush(flush), .issue_valid(issue_valid),
        .issue_index(issue_index), .issue_instr(issue_instr), .count(count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: entries kept oldest-first in a queue; scoreboard as plain countdown integers.
    typedef struct {
        int                 slot;
        logic [INSTR_W-1:0] instr;
        int                 rd, rs1, rs2;
        bit                 rdl, r1l, r2l;
    } ent_t;

    ent_t               mq[$];
    int                 msb[REGNUM];
    bit                 e_iv = 0;
    int                 e_idx = 0;
    logic [INSTR_W-1:0] e_instr = '0;
    bit                 mdl_on = 0;

    function automatic bit m_blocked(int k);
        bit b = 0;
        if (mq[k].r1l && msb[mq[k].rs1] != 0) b = 1;
        if (mq[k].r2l && msb[mq[k].rs2] != 0) b = 1;
        if (mq[k].rdl && msb[mq[k].rd]  != 0) b = 1;
        for (int m = 0; m < k; m++) begin
            if (mq[m].rdl && mq[k].r1l && mq[m].rd == mq[k].rs1) b = 1;
            if (mq[m].rdl && mq[k].r2l && mq[m].rd == mq[k].rs2) b = 1;
            if (mq[m].rdl && mq[k].rdl && mq[m].rd == mq[k].rd)  b = 1;
            if (mq[k].rdl && mq[m].r1l && mq[m].rs1 == mq[k].rd) b = 1;
            if (mq[k].rdl && mq[m].r2l && mq[m].rs2 == mq[k].rd) b = 1;
        end
        return b;
    endfunction

    always @(posedge clk) begin : mdl
        int   sel, fs;
        bit   acc, iss;
        bit   used[BS];
        ent_t ne;
        mdl_on = 1;
        if (rst) begin
            mq.delete();
            for (int r = 0; r < REGNUM; r++) msb[r] = 0;
            e_iv = 0; e_idx = 0; e_instr = '0;
        end else begin
            acc = in_valid && (mq.size() < BS) && !flush;
            sel = -1;
            for (int k = 0; k < mq.size(); k++) begin
                if (sel < 0 && !m_blocked(k)) sel = k;
            end
            iss = start && (sel >= 0) && !flush;
            for (int s = 0; s < BS; s++) used[s] = 0;
            foreach (mq[i]) used[mq[i].slot] = 1;
            fs = -1;
            for (int s = BS - 1; s >= 0; s--) if (!used[s]) fs = s;
            for (int r = 0; r < REGNUM; r++) if (msb[r] > 0) msb[r]--;
            e_iv = iss;
            if (iss) begin
                e_idx = mq[sel].slot;
                e_instr = mq[sel].instr;
                if (mq[sel].rdl) msb[mq[sel].rd] = LAT;
                mq.delete(sel);
            end
            if (flush) mq.delete();
            if (acc) begin
                ne.slot = fs; ne.instr = in_instr;
                ne.rd = int'(in_instr[11:7]); ne.rs1 = int'(in_instr[19:15]); ne.rs2 = int'(in_instr[24:20]);
                ne.rdl = in_regwrite && ne.rd != 0;
                ne.r1l = ne.rs1 != 0;
                ne.r2l = !in_alusrc && ne.rs2 != 0;
                mq.push_back(ne);
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            check("mdl_issue_valid", issue_valid, e_iv);
            check("mdl_issue_index", issue_index, e_idx);
            check("mdl_issue_instr", issue_instr, e_instr);
            check("mdl_count", count, mq.size());
            check("mdl_in_ready", in_ready, (!rst && mq.size() < BS));
        end
    end

    function automatic logic [31:0] mk(int rd, int rs1, int rs2, int tag);
        logic [31:0] v;
        v = '0;
        v[6:0]   = 7'h13;
        v[11:7]  = rd[4:0];
        v[19:15] = rs1[4:0];
        v[24:20] = rs2[4:0];
        v[31:25] = tag[6:0];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] ins, input logic alu, input logic rw);
        in_valid = 1; in_instr = ins; in_alusrc = alu; in_regwrite = rw;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) begin step(); mid(); end
    endtask

    initial begin
        rst = 1; in_valid = 0; in_instr = '0; in_alusrc = 0; in_regwrite = 0; start = 0; flush = 0;
        step(); step(); mid();
        check("rst_in_ready", in_ready, 0);
        check("rst_count", count, 0);
        check("rst_issue_valid", issue_valid, 0);
        check("rst_issue_index", issue_index, 0);
        check("rst_issue_instr", issue_instr, 0);
        step(); rst = 0; mid();
        check("post_rst_in_ready", in_ready, 1);

        // Minimum latency: accept in c0, issue visible in c2.
        step(); start = 1; offer(mk(1, 2, 0, 1), 1, 1); mid();
        step(); in_valid = 0; mid();
        check("t1_c1_iv", issue_valid, 0);
        check("t1_c1_count", count, 1);
        step(); mid();
        check("t1_c2_iv", issue_valid, 1);
        check("t1_c2_idx", issue_index, 0);
        check("t1_c2_count", count, 0);
        idle(4);

        // RAW through the scoreboard: A issues c2, dependent B issues c5.
        step(); offer(mk(1, 0, 0, 2), 1, 1); mid();
        step(); offer(mk(5, 1, 0, 3), 1, 1); mid();
        check("t2_c1_iv", issue_valid, 0);
        step(); in_valid = 0; mid();
        check("t2_c2_iv", issue_valid, 1);
        check("t2_c2_instr", issue_instr, mk(1, 0, 0, 2));
        step(); mid(); check("t2_c3_iv", issue_valid, 0);
        step(); mid(); check("t2_c4_iv", issue_valid, 0);
        step(); mid();
        check("t2_c5_iv", issue_valid, 1);
        check("t2_c5_idx", issue_index, 1);
        idle(4);

        // Stalled start: oldest first once enabled.
        step(); start = 0; offer(mk(1, 0, 0, 4), 1, 1); mid();
        step(); offer(mk(3, 4, 0, 5), 1, 1); mid();
        step(); in_valid = 0; start = 1; mid();
        check("t3_c2_count", count, 2);
        check("t3_c2_iv", issue_valid, 0);
        step(); mid();
        check("t3_c3_idx", issue_index, 0);
        check("t3_c3_instr", issue_instr, mk(1, 0, 0, 4));
        step(); mid();
        check("t3_c4_iv", issue_valid, 1);
        check("t3_c4_instr", issue_instr, mk(3, 4, 0, 5));
        check("t3_c4_count", count, 0);
        idle(4);

        // Fill to BS with start low, then release.
        start = 0;
        for (int i = 0; i < BS; i++) begin
            step(); offer(mk(i + 1, 0, 0, 16 + i), 1, 1); mid();
        end
        step(); offer(mk(20, 0, 0, 40), 1, 1); start = 1; mid();
        check("t4_full_count", count, BS);
        check("t4_full_ready", in_ready, 0);
        step(); in_valid = 0; mid();
        check("t4_iv", issue_valid, 1);
        check("t4_idx", issue_index, 0);
        check("t4_count", count, BS - 1);
        check("t4_ready", in_ready, 1);
        idle(22);

        // Register 0 and immediate rs2 never stall.
        step(); offer(mk(0, 7, 0, 50), 1, 1); mid();
        step(); offer(mk(8, 0, 0, 51), 1, 1); mid();
        step(); offer(mk(9, 0, 8, 52), 1, 1); mid();
        check("t5_c2_idx", issue_index, 0);
        check("t5_c2_iv", issue_valid, 1);
        step(); in_valid = 0; mid();
        check("t5_c3_iv", issue_valid, 1);
        check("t5_c3_idx", issue_index, 1);
        step(); mid();
        check("t5_c4_iv", issue_valid, 1);
        check("t5_c4_instr", issue_instr, mk(9, 0, 8, 52));
        idle(4);

        // Flush with 5 entries and an offered instruction.
        start = 0;
        for (int i = 0; i < 5; i++) begin
            step(); offer(mk(10 + i, 0, 0, 60 + i), 1, 1); mid();
        end
        step(); start = 1; offer(mk(15, 0, 0, 65), 1, 1); mid();
        step(); flush = 1; offer(mk(16, 0, 0, 66), 1, 1); mid();
        check("t6_pre_count", count, 5);
        check("t6_pre_iv", issue_valid, 1);
        step(); flush = 0; offer(mk(17, 10, 0, 67), 1, 1); mid();
        check("t6_flush_count", count, 0);
        check("t6_flush_iv", issue_valid, 0);
        step(); in_valid = 0; mid();
        check("t6_c8_iv", issue_valid, 0);
        check("t6_c8_count", count, 1);
        step(); mid();
        check("t6_c9_iv", issue_valid, 1);
        check("t6_c9_instr", issue_instr, mk(17, 10, 0, 67));
        step(); flush = 1; mid();
        step(); flush = 0; mid();
        check("t6_empty_flush_count", count, 0);
        check("t6_empty_flush_iv", issue_valid, 0);
        idle(4);

        // Reset mid-operation with a pending scoreboard register.
        step(); start = 0; offer(mk(20, 0, 0, 70), 1, 1); mid();
        step(); start = 1; offer(mk(21, 0, 0, 71), 1, 1); mid();
        step(); rst = 1; offer(mk(22, 0, 0, 72), 1, 1); mid();
        check("t7_rst_ready", in_ready, 0);
        check("t7_c2_iv", issue_valid, 1);
        step(); rst = 0; offer(mk(23, 20, 0, 73), 1, 1); mid();
        check("t7_post_count", count, 0);
        check("t7_post_iv", issue_valid, 0);
        check("t7_post_idx", issue_index, 0);
        check("t7_post_instr", issue_instr, 0);
        check("t7_post_ready", in_ready, 1);
        step(); in_valid = 0; mid();
        check("t7_c4_count", count, 1);
        step(); mid();
        check("t7_c5_iv", issue_valid, 1);
        check("t7_c5_instr", issue_instr, mk(23, 20, 0, 73));
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
